html_char_fetcher: RTL
======================

Name: html_char_fetcher

Overview:
Upstream stage of html_parser. Walks an HTML document stored in a synchronous-read character memory and presents one character at a time on `char` with a valid/next handshake. Collapses runs of HTML whitespace (space, tab, LF, CR) into a single space, drops leading whitespace, and flags end of document on a NUL byte or the last address. Lets the parser and its renderers hold a character for as many cycles as drawing takes.

Parameters:
ADDR_WIDTH, 12, width of the document memory address
LAST_ADDR, 4095, highest valid document address; the fetch stops after this address

Ports:
clock  in  1  system clock; all state changes on posedge
enable  in  1  synchronous active-low reset (enable / ~reset); 0 at a posedge resets the block
start  in  1  begin a fetch pass from address 0; honoured in IDLE and DONE only
next  in  1  consumer has finished with the current char; honoured in PRESENT only
mem_data  in  8  memory read data; valid the cycle after mem_addr is sampled
mem_addr  out  ADDR_WIDTH  memory read address
char  out  8  current character (`CHAR_BITES`), held stable while char_valid=1
char_valid  out  1  char is valid
eof  out  1  end of document reached; held until start or reset
busy  out  1  high in READ, EVAL and PRESENT

Behaviour:
- Reset (enable=0 at a posedge): state=IDLE, mem_addr=0, char=0, char_valid=0, eof=0, prev_ws=1. Reset overrides every other input in every state, including mid-pass.
- States: IDLE, READ, EVAL, PRESENT, DONE.
- IDLE or DONE with start=1: mem_addr<=0, prev_ws<=1, eof<=0, go to READ.
- READ: mem_addr is held; memory samples it at this edge. Go to EVAL.
- EVAL: classify mem_data in this priority order:
  - mem_data==8'h00: eof<=1, go to DONE.
  - Whitespace (8'h20, 8'h09, 8'h0A, 8'h0D) with prev_ws=1 (skip):
    - if mem_addr==LAST_ADDR: eof<=1, go to DONE;
    - else mem_addr<=mem_addr+1, go to READ.
  - Otherwise: char<=(whitespace ? 8'h20 : mem_data), prev_ws<=whitespace, char_valid<=1, go to PRESENT.
- PRESENT: char and char_valid are held while next=0. On next=1: char_valid<=0, then
  - if mem_addr==LAST_ADDR: eof<=1, go to DONE;
  - else mem_addr<=mem_addr+1, go to READ.
- DONE: char_valid=0 and eof=1 are held. char keeps the last value.
- Ignored inputs: next outside PRESENT; start outside IDLE and DONE.
- mem_addr never wraps; it stops at LAST_ADDR.
- Latency:
  - start sampled at edge k gives char_valid high after edge k+2.
  - next sampled at edge n gives char_valid low after edge n and the following char valid after edge n+2 at the earliest.
  - Each skipped whitespace byte adds 2 cycles.
- char_valid is never high in the same cycle as eof.
- A single trailing space before NUL is emitted; this is legal.
- '<', '>' and all other bytes pass through unmodified. Tag parsing is the consumer's job.
- busy = (state is READ, EVAL or PRESENT).

Test Plan:
- Reset then idle: hold enable=0 for 2 cycles, then enable=1 with start=0 -> char_valid=0, eof=0, busy=0, mem_addr=0 indefinitely.
- Basic stream: memory "<b>hi</b>\0", next pulsed 1 cycle after each char_valid rise -> chars 3C 62 3E 68 69 3C 2F 62 3E in order; eof=1 after the NUL at addr 9; first char_valid 2 cycles after start.
- Whitespace collapse: memory "  a \t\n b\0" -> exactly 61 20 62 then eof. No leading space. mem_addr reaches 8.
- Backpressure: memory "xy\0", next held 0 for 20 cycles -> char=78 stable with char_valid=1 for all 20 cycles; mem_addr stays 0; then 79 is delivered after next.
- Last address: LAST_ADDR=3, memory "abcd" with no NUL -> 61 62 63 64 then eof=1; mem_addr stops at 3 and does not wrap.
- Reset mid-pass and restart: enable=0 while PRESENT on addr 2 -> next cycle IDLE, char_valid=0, mem_addr=0. Later, start in DONE restarts from addr 0 with eof cleared.

Source files
------------

// File: rtl/html_char_fetcher.sv
// Character fetch stage for the HTML parser: reads a byte-wide document memory,
// collapses whitespace runs to a single space, drops leading whitespace and
// presents one character at a time with a valid/next handshake.
module html_char_fetcher #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LAST_ADDR  = 4095
) (
  input  logic                  clock,
  input  logic                  enable,
  input  logic                  start,
  input  logic                  next,
  input  logic [7:0]            mem_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            char,
  output logic                  char_valid,
  output logic                  eof,
  output logic                  busy
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StEval,
    StPresent,
    StDone
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(LAST_ADDR);
  localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            char_q, char_d;
  logic                  char_valid_q, char_valid_d;
  logic                  eof_q, eof_d;
  // Set when the previous emitted char was whitespace (or at pass start),
  // so further whitespace is skipped.
  logic                  prev_ws_q, prev_ws_d;

  logic is_ws;
  logic at_last;

  // Byte classification and end-of-range detect.
  always_comb begin
    is_ws   = (mem_data == 8'h20) || (mem_data == 8'h09) ||
              (mem_data == 8'h0A) || (mem_data == 8'h0D);
    at_last = (mem_addr_q == LastAddr);
  end

  // Next-state and datapath updates for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    char_d       = char_q;
    char_valid_d = char_valid_q;
    eof_d        = eof_q;
    prev_ws_d    = prev_ws_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mem_addr_d   = '0;
          prev_ws_d    = 1'b1;
          eof_d        = 1'b0;
          char_valid_d = 1'b0;
          state_d      = StRead;
        end
      end
      // Memory samples mem_addr at the edge leaving this state.
      StRead: begin
        state_d = StEval;
      end
      StEval: begin
        if (mem_data == 8'h00) begin
          eof_d   = 1'b1;
          state_d = StDone;
        end else if (is_ws && prev_ws_q) begin
          if (at_last) begin
            eof_d   = 1'b1;
            state_d = StDone;
          end else begin
            mem_addr_d = mem_addr_q + AddrOne;
            state_d    = StRead;
          end
        end else begin
          char_d       = is_ws ? 8'h20 : mem_data;
          prev_ws_d    = is_ws;
          char_valid_d = 1'b1;
          state_d      = StPresent;
        end
      end
      StPresent: begin
        if (next) begin
          char_valid_d = 1'b0;
          if (at_last) begin
            eof_d   = 1'b1;
            state_d = StDone;
          end else begin
            mem_addr_d = mem_addr_q + AddrOne;
            state_d    = StRead;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!enable) begin
      state_q      <= StIdle;
      mem_addr_q   <= '0;
      char_q       <= 8'h00;
      char_valid_q <= 1'b0;
      eof_q        <= 1'b0;
      prev_ws_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      eof_q        <= eof_d;
      prev_ws_q    <= prev_ws_d;
    end
  end

  // Registered outputs; busy decoded from state.
  always_comb begin
    mem_addr   = mem_addr_q;
    char       = char_q;
    char_valid = char_valid_q;
    eof        = eof_q;
    busy       = (state_q == StRead) || (state_q == StEval) || (state_q == StPresent);
  end

endmodule
